// File: rtl/player_pkg.sv
// Shared encodings and constants for the audio player control path.
package player_pkg;

  typedef enum logic [1:0] {
    MODE_SEQ     = 2'd0,
    MODE_REPEAT  = 2'd1,
    MODE_SHUFFLE = 2'd2,
    MODE_SEQ_ALT = 2'd3
  } play_mode_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 (1-indexed) as a bit mask
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  localparam logic [3:0] SEC_L_MAX = 4'd9;
  localparam logic [3:0] SEC_H_MAX = 4'd5;
  localparam logic [3:0] MIN_L_MAX = 4'd9;
  localparam logic [3:0] MIN_H_MAX = 4'd9;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cmd_debounce.sv
// Two-flop synchroniser, counter debouncer and rising-edge event with optional auto-repeat.
module cmd_debounce #(
  parameter int unsigned DEB_CYC       = 1000000,
  parameter int unsigned REPEAT_CYC    = 10000000,
  parameter bit          ENABLE_REPEAT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic evt
);

  localparam int unsigned DW = $clog2(DEB_CYC + 1);
  localparam int unsigned RW = $clog2(REPEAT_CYC + 1);

  logic          s1, s2, deb;
  logic [DW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic          settle, rise, rep;

  always_comb begin
    settle = (s2 != deb) && (cnt == DW'(DEB_CYC - 1));
    rise   = settle && s2;
    rep    = ENABLE_REPEAT && deb && (rcnt == RW'(REPEAT_CYC - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      deb  <= 1'b0;
      cnt  <= '0;
      rcnt <= '0;
      evt  <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (settle) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
      // repeat timer starts from zero on the debounced rising edge
      if (!deb || !ENABLE_REPEAT || rep) rcnt <= '0;
      else                               rcnt <= rcnt + RW'(1);
      evt <= rise | rep;
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// Player control: debounced volume/track commands, play-mode track advance, BCD elapsed time.
module player_ctrl
  import player_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned VOL_W      = 8,
  parameter int unsigned VOL_STEP   = 16,
  parameter int unsigned VOL_MAX    = 254,
  parameter int unsigned VOL_RST    = 32,
  parameter int unsigned NUM_TRACKS = 32,
  parameter int unsigned DEB_CYC    = 1000000,
  parameter int unsigned REPEAT_CYC = 10000000,
  parameter int unsigned TICK_DIV   = 100000000
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_SRC-1:0]            inc_vol,
  input  logic [NUM_SRC-1:0]            dec_vol,
  input  logic [NUM_SRC-1:0]            next_trk,
  input  logic [NUM_SRC-1:0]            prev_trk,
  input  logic [1:0]                    play_mode,
  input  logic                          track_end,
  output logic [VOL_W-1:0]              vol,
  output logic [$clog2(NUM_TRACKS)-1:0] track,
  output logic                          track_chg,
  output logic [3:0]                    sec_l,
  output logic [3:0]                    sec_h,
  output logic [3:0]                    min_l,
  output logic [3:0]                    min_h
);

  localparam int unsigned TW  = $clog2(NUM_TRACKS);
  localparam int unsigned KW  = $clog2(TICK_DIV + 1);
  localparam logic [TW:0]    NT   = (TW+1)'(NUM_TRACKS);
  localparam logic [TW-1:0]  LAST = TW'(NUM_TRACKS - 1);
  localparam logic [VOL_W:0] STEP = (VOL_W+1)'(VOL_STEP);
  localparam logic [VOL_W:0] VMAX = (VOL_W+1)'(VOL_MAX);

  logic inc_e, dec_e, nxt_e, prv_e;

  cmd_debounce #(.DEB_CYC(DEB_CYC), .REPEAT_CYC(REPEAT_CYC), .ENABLE_REPEAT(1'b1))
    u_inc (.clk(CLK), .rst(RST), .din(|inc_vol), .evt(inc_e));
  cmd_debounce #(.DEB_CYC(DEB_CYC), .REPEAT_CYC(REPEAT_CYC), .ENABLE_REPEAT(1'b1))
    u_dec (.clk(CLK), .rst(RST), .din(|dec_vol), .evt(dec_e));
  cmd_debounce #(.DEB_CYC(DEB_CYC), .REPEAT_CYC(REPEAT_CYC), .ENABLE_REPEAT(1'b0))
    u_nxt (.clk(CLK), .rst(RST), .din(|next_trk), .evt(nxt_e));
  cmd_debounce #(.DEB_CYC(DEB_CYC), .REPEAT_CYC(REPEAT_CYC), .ENABLE_REPEAT(1'b0))
    u_prv (.clk(CLK), .rst(RST), .din(|prev_trk), .evt(prv_e));

  logic [7:0]       lfsr;
  logic [KW-1:0]    tick;
  logic [VOL_W-1:0] vol_nxt;
  logic [VOL_W:0]   vol_sum;
  logic [TW-1:0]    track_nxt, trk_inc, trk_dec, shuf;
  logic [TW:0]      idx;
  logic             chg;

  always_comb begin
    vol_nxt = vol;
    vol_sum = {1'b0, vol} + STEP;
    if (inc_e && !dec_e)
      vol_nxt = ({1'b0, vol} >= STEP) ? vol - STEP[VOL_W-1:0] : '0;
    else if (dec_e && !inc_e)
      vol_nxt = (vol_sum > VMAX) ? VMAX[VOL_W-1:0] : vol_sum[VOL_W-1:0];
  end

  always_comb begin
    trk_inc = (track == LAST) ? '0 : track + TW'(1);
    trk_dec = (track == '0) ? LAST : track - TW'(1);
    idx = {1'b0, lfsr[TW-1:0]};
    if (idx >= NT) idx = idx - NT;
    shuf = idx[TW-1:0];
    if (shuf == track) shuf = (shuf == LAST) ? '0 : shuf + TW'(1);
    track_nxt = track;
    chg       = 1'b0;
    // any user track event masks a coincident track_end
    if (nxt_e || prv_e) begin
      if (nxt_e && !prv_e) begin
        track_nxt = trk_inc;
        chg       = 1'b1;
      end else if (prv_e && !nxt_e) begin
        track_nxt = trk_dec;
        chg       = 1'b1;
      end
    end else if (track_end) begin
      chg = 1'b1;
      case (play_mode_e'(play_mode))
        MODE_REPEAT:  track_nxt = track;
        MODE_SHUFFLE: track_nxt = shuf;
        default:      track_nxt = trk_inc;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vol       <= VOL_W'(VOL_RST);
      track     <= '0;
      track_chg <= 1'b0;
      lfsr      <= LFSR_SEED;
      tick      <= '0;
      sec_l     <= '0;
      sec_h     <= '0;
      min_l     <= '0;
      min_h     <= '0;
    end else begin
      vol       <= vol_nxt;
      track     <= track_nxt;
      track_chg <= chg;
      lfsr      <= lfsr_next(lfsr);
      if (chg) begin
        tick  <= '0;
        sec_l <= '0;
        sec_h <= '0;
        min_l <= '0;
        min_h <= '0;
      end else if (tick == KW'(TICK_DIV - 1)) begin
        tick <= '0;
        if (sec_l == SEC_L_MAX) begin
          sec_l <= '0;
          if (sec_h == SEC_H_MAX) begin
            sec_h <= '0;
            if (min_l == MIN_L_MAX) begin
              min_l <= '0;
              min_h <= (min_h == MIN_H_MAX) ? '0 : min_h + 4'd1;
            end else begin
              min_l <= min_l + 4'd1;
            end
          end else begin
            sec_h <= sec_h + 4'd1;
          end
        end else begin
          sec_l <= sec_l + 4'd1;
        end
      end else begin
        tick <= tick + KW'(1);
      end
    end
  end

endmodule

// File: doc/player_ctrl.md
PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
  NUM_SRC, 2, number of command sources (board buttons, Bluetooth, ...)
  VOL_W, 8, width of the volume attenuation word
  VOL_STEP, 16, attenuation change per volume event
  VOL_MAX, 254, maximum attenuation (silent)
  VOL_RST, 32, attenuation after reset
  NUM_TRACKS, 32, track count, 2..64
  DEB_CYC, 1000000, cycles an input must be stable to be accepted
  REPEAT_CYC, 10000000, hold time before and between volume auto-repeats
  TICK_DIV, 100000000, CLK cycles per elapsed-time second
REQ-002 Ports SHALL be (name, direction, width, meaning):
  CLK  in  1  single system clock, rising edge
  RST  in  1  synchronous, active-high reset
  inc_vol  in  NUM_SRC  volume-up request per source, level
  dec_vol  in  NUM_SRC  volume-down request per source, level
  next_trk  in  NUM_SRC  next-track request per source, level
  prev_trk  in  NUM_SRC  previous-track request per source, level
  play_mode  in  2  0=sequential, 1=repeat-one, 2=shuffle, 3=treated as 0
  track_end  in  1  one-cycle pulse from decoder at end of track
  vol  out  VOL_W  attenuation, 0=loudest
  track  out  clog2(NUM_TRACKS)  current track index
  track_chg  out  1  one-cycle pulse when track restarts or changes
  sec_l, sec_h, min_l, min_h  out  4 each  BCD elapsed time in current track
REQ-003 Reset is synchronous and active-high, sampled on the rising edge of CLK; this is fixed.

Function
REQ-004 Each command SHALL be OR-reduced across sources, synchronised through two flops, then debounced: output level changes only after DEB_CYC consecutive equal samples.
REQ-005 A debounced rising edge SHALL produce one event; vol/track register updates on the following cycle (total latency 2 + DEB_CYC + 1 cycles from input).
REQ-006 Volume held debounced-high SHALL auto-repeat: further events after REPEAT_CYC cycles, then every REPEAT_CYC cycles until release; track commands never repeat.
REQ-007 Inc event: vol = max(vol - VOL_STEP, 0); dec event: vol = min(vol + VOL_STEP, VOL_MAX); arithmetic in VOL_W+1 bits, no wrap.
REQ-008 Simultaneous inc and dec events SHALL be ignored; simultaneous next and prev events SHALL be ignored.
REQ-009 Next: track = (track+1) mod NUM_TRACKS; prev: track = track-1, 0 wraps to NUM_TRACKS-1; both assert track_chg.
REQ-010 On track_end: mode 0 -> as next; mode 1 -> track unchanged, track_chg pulses; mode 2 -> shuffle pick.
REQ-011 Shuffle pick: 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 0xA5) advancing every cycle; idx = low clog2(NUM_TRACKS) bits, minus NUM_TRACKS if >= NUM_TRACKS; if idx == track, use (idx+1) mod NUM_TRACKS.
REQ-012 A user next/prev event in the same cycle as track_end SHALL win; track_end is dropped.
REQ-013 Elapsed time: tick counter 0..TICK_DIV-1; on wrap sec increments BCD 00..59, carry to min 00..99, 99:59 wraps to 00:00.
REQ-014 When track_chg asserts, tick counter and time SHALL clear in that same cycle's update; counting resumes next cycle.
REQ-015 Volume and track paths SHALL be independent; a volume event never affects time or track.

Reset
REQ-016 On RST: vol=VOL_RST, track=0, track_chg=0, time=00:00, tick=0, LFSR=0xA5, synchronisers/debouncers/repeat counters cleared to low; RST mid-hold SHALL abort auto-repeat and require a fresh rising edge.

Structure
REQ-017 Mode encodings, LFSR seed/taps and BCD limits SHALL live in shared package player_pkg.
REQ-018 Debounce+edge logic SHALL be a sub-module cmd_debounce (params DEB_CYC, REPEAT_CYC, ENABLE_REPEAT), instantiated four times.

Verification (DEB_CYC=4, REPEAT_CYC=20, TICK_DIV=10, NUM_TRACKS=5)
REQ-019 inc_vol[1] high 10 cycles from vol=32 -> vol=16 after 7 cycles, no second step; glitch of 2 cycles -> no change.
REQ-020 dec_vol[0] held 60 cycles from vol=224 -> 240, 254 at +20, 254 at +40 (saturated).
REQ-021 track=4, next pulse -> track=0 with track_chg; track=0, prev -> 4; next and prev together -> unchanged, no pulse.
REQ-022 mode=1, track=2, track_end -> track=2, track_chg=1, time 00:00; mode=2 -> new track != 2 and < 5.
REQ-023 Run 600 cycles -> 01:00; RST asserted mid-count -> next cycle all outputs at reset values.
